wb_stage_skid: RTL and testbench
================================

Name: wb_stage_skid

Overview:
- Parametrised successor to the single-lane WB pipeline register.
- Carries LANES parallel writeback slots from MEM to the register file, HI/LO and CP0 commit points.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and independent of out_ready.
- Adds synchronous flush, r0-write suppression and same-register lane-collision resolution.

Parameters:
- DATA_W, 32, result/PC width
- REG_AW, 5, register-number width
- LANES, 2, writeback slots per bundle (1..4)
- RESET_PC, 32'hbfc00000, PC value held in empty or flushed slots

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard everything held; synchronous
- in_valid  in  1  bundle present at input
- in_ready  out  1  stage can accept a bundle; registered
- in_lane_valid  in  LANES  per-lane instruction present
- in_pc  in  LANES*DATA_W  per-lane PC
- in_result  in  LANES*DATA_W  per-lane write data
- in_wreg  in  LANES*REG_AW  per-lane destination register
- in_regwrite  in  LANES  per-lane register-file write request
- in_hilo_we  in  1  HI/LO write request (lane 0 only)
- in_hilo  in  64  HI/LO data
- in_cp0_we  in  1  CP0 write request (lane 0 only)
- out_valid  out  1  bundle present at output
- out_ready  in  1  consumer accepts the bundle
- out_pc  out  LANES*DATA_W  per-lane PC
- out_result  out  LANES*DATA_W  per-lane write data
- out_wreg  out  LANES*REG_AW  per-lane destination register
- out_regwrite  out  LANES  qualified per-lane write enable
- out_hilo_we  out  1  qualified HI/LO write enable
- out_hilo  out  64  HI/LO data
- out_cp0_we  out  1  qualified CP0 write enable

Behaviour:
- Two storage entries: MAIN (drives outputs) and SKID. State is EMPTY, ONE (MAIN valid) or TWO (MAIN+SKID valid).
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = registered ~SKID.valid, so it is 1 in EMPTY and ONE.
- out_valid = MAIN.valid.
- Latency: an input accepted in cycle N appears at the outputs in cycle N+1 when MAIN is empty or is draining that cycle.
- EMPTY: on in_fire, go to ONE and load MAIN.
- ONE, in_fire & out_fire: MAIN <- input; stay ONE.
- ONE, in_fire only: SKID <- input; go to TWO (in_ready drops next cycle).
- ONE, out_fire only: go to EMPTY.
- TWO, out_fire: MAIN <- SKID; go to ONE. in_valid is ignored in TWO because in_ready = 0.
- Ordering is strict FIFO; no bundle is ever dropped or duplicated.
- Qualification:
  - out_regwrite[i] = MAIN.valid & lane_valid[i] & regwrite[i] & (wreg[i] != 0).
  - out_hilo_we and out_cp0_we = MAIN.valid & the stored flag & lane_valid[0].
- Collision: if two qualified lanes share a wreg, the higher-index (younger) lane wins. The lower lane's out_regwrite is forced to 0. This is resolved at load time, not on outputs.
- Empty or flushed slots hold: pc = RESET_PC, result = 0, wreg = 0, all enables 0.
- Reset and flush:
  - Either one clears both entries to the empty values.
  - Next cycle: out_valid = 0 and in_ready = 1.
  - Flush beats a simultaneous in_fire; the input bundle is discarded.
  - Reset beats flush.
  - Reset mid-TWO discards both entries.
- Outputs are held stable while out_valid & ~out_ready; every out_* signal is a register or a pure AND of registers.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output port retire_cnt (out, 32): count of retired instructions.
  - On out_fire, retire_cnt increments by the popcount of MAIN.lane_valid, wrapping modulo 2^32.
  - Reset value 0; cleared by reset, not by flush.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then out_ready = 1; stream 3 bundles (lane0 wreg 1..3, result 0x11/0x22/0x33). Expect out_valid one cycle after each accept, same order and data, and in_ready = 1 throughout.
- Hold out_ready = 0 and send 2 bundles. Expect the first in MAIN, the second in SKID, and in_ready = 0 from the next cycle. Raise out_ready: expect both drain in order, then in_ready = 1.
- Both lanes wreg = 5, regwrite = 11, results 0xAAAA/0xBBBB. Expect out_regwrite = 2'b10 with lane1 result 0xBBBB. With wreg = 0 on lane 1, expect out_regwrite[1] = 0.
- In state TWO, assert flush together with in_valid. Next cycle expect out_valid = 0, out_pc = {2{32'hbfc00000}}, all enables 0, in_ready = 1, and the input discarded.
- Bundle with in_hilo_we = 1, in_hilo = 64'h1234_5678_9abc_def0, in_cp0_we = 1, lane_valid = 2'b01. Expect both enables high while MAIN is valid and hilo passed unchanged. Repeat with lane_valid = 2'b10: expect both enables 0.
- With WB_RETIRE_CNT_EN defined, retire bundles with lane_valid 11, 01, 11. Expect retire_cnt = 5. Preload 0xFFFF_FFFF via 2^32-1 single-lane fires or a bench force, retire lane_valid 11, and expect 1 (wrap).

Source files
------------

// File: rtl/wb_stage_skid.sv
// wb_stage_skid: multi-lane MEM->WB pipeline register with a 2-entry skid buffer.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
//   The producer holds in_* stable while in_valid & ~in_ready. The stage holds out_*
//   stable while out_valid & ~out_ready. in_ready comes straight from a flop and does
//   not depend on out_ready.
// Lane write enables are qualified when a bundle is loaded. This covers r0 suppression
// and same-register collisions, where the younger (higher-index) lane wins.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module wb_stage_skid #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter int                LANES    = 2,
    parameter logic [DATA_W-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES*DATA_W-1:0]  in_pc,
    input  logic [LANES*DATA_W-1:0]  in_result,
    input  logic [LANES*REG_AW-1:0]  in_wreg,
    input  logic [LANES-1:0]         in_regwrite,
    input  logic                     in_hilo_we,
    input  logic [63:0]              in_hilo,
    input  logic                     in_cp0_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATA_W-1:0]  out_pc,
    output logic [LANES*DATA_W-1:0]  out_result,
    output logic [LANES*REG_AW-1:0]  out_wreg,
    output logic [LANES-1:0]         out_regwrite,
    output logic                     out_hilo_we,
    output logic [63:0]              out_hilo,
    output logic                     out_cp0_we,
    output logic [1:0]               dbg_state
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]              retire_cnt
`endif
);

    // Bit 0 of the state means MAIN is valid and bit 1 means SKID is valid.
    // Both valids are therefore plain flop outputs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    typedef struct packed {
        logic [LANES-1:0]        lane_valid;
        logic [LANES*DATA_W-1:0] pc;
        logic [LANES*DATA_W-1:0] result;
        logic [LANES*REG_AW-1:0] wreg;
        logic [LANES-1:0]        regwrite;  // already qualified and collision-resolved
        logic                    hilo_we;
        logic [63:0]             hilo;
        logic                    cp0_we;
    } entry_t;

    state_t state, next_state;
    entry_t main_q, skid_q, in_entry, empty_entry;
    logic   ready_q;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid_in, clear_main, clear_skid;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = state[0] & out_ready;

    // Contents held by an empty or flushed entry.
    always_comb begin
        empty_entry            = '0;
        empty_entry.pc         = {LANES{RESET_PC}};
    end

    // Build the entry for the incoming bundle. Lane write enables are resolved here.
    always_comb begin
        logic [LANES-1:0] qual;
        logic [LANES-1:0] win;
        in_entry            = '0;
        in_entry.lane_valid = in_lane_valid;
        in_entry.pc         = in_pc;
        in_entry.result     = in_result;
        in_entry.wreg       = in_wreg;
        in_entry.hilo_we    = in_hilo_we;
        in_entry.hilo       = in_hilo;
        in_entry.cp0_we     = in_cp0_we;
        for (int i = 0; i < LANES; i++) begin
            qual[i] = in_lane_valid[i] & in_regwrite[i] &
                      (in_wreg[i*REG_AW +: REG_AW] != '0);
        end
        win = qual;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (qual[j] && (in_wreg[j*REG_AW +: REG_AW] == in_wreg[i*REG_AW +: REG_AW]))
                    win[i] = 1'b0;
            end
        end
        in_entry.regwrite = win;
    end

    // Next-state and entry-move decode for the skid FSM.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        clear_main     = 1'b0;
        clear_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    next_state   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid_in = 1'b1;
                    next_state   = ST_TWO;
                end else if (out_fire) begin
                    clear_main   = 1'b1;
                    next_state   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    clear_skid     = 1'b1;
                    next_state     = ST_ONE;
                end
            end
            default: begin
                clear_main = 1'b1;
                clear_skid = 1'b1;
                next_state = ST_EMPTY;
            end
        endcase
    end

    // State and storage registers. Reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= empty_entry;
            skid_q  <= empty_entry;
        end else begin
            state   <= next_state;
            ready_q <= ~next_state[1];
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            else if (clear_main)     main_q <= empty_entry;
            if (load_skid_in)        skid_q <= in_entry;
            else if (clear_skid)     skid_q <= empty_entry;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = state[0];
    assign dbg_state    = state;
    assign out_pc       = main_q.pc;
    assign out_result   = main_q.result;
    assign out_wreg     = main_q.wreg;
    assign out_hilo     = main_q.hilo;
    assign out_regwrite = main_q.regwrite & {LANES{state[0]}};
    assign out_hilo_we  = state[0] & main_q.hilo_we & main_q.lane_valid[0];
    assign out_cp0_we   = state[0] & main_q.cp0_we & main_q.lane_valid[0];

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + {31'd0, v[i]};
        return n;
    endfunction

    // Retired-instruction counter. Flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset)         retire_cnt_q <= '0;
        else if (out_fire) retire_cnt_q <= retire_cnt_q + popcount(main_q.lane_valid);
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_skid.sv
// Directed testbench for wb_stage_skid with the default parameters (2 lanes, 32-bit).
module tb_wb_stage_skid;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_lane_valid, in_regwrite, out_regwrite, dbg_state;
  logic [63:0] in_pc, in_result, out_pc, out_result;
  logic [9:0]  in_wreg, out_wreg;
  logic        in_hilo_we, in_cp0_we, out_hilo_we, out_cp0_we;
  logic [63:0] in_hilo, out_hilo;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_result(in_result),
    .in_wreg(in_wreg), .in_regwrite(in_regwrite),
    .in_hilo_we(in_hilo_we), .in_hilo(in_hilo), .in_cp0_we(in_cp0_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_wreg(out_wreg),
    .out_regwrite(out_regwrite), .out_hilo_we(out_hilo_we),
    .out_hilo(out_hilo), .out_cp0_we(out_cp0_we),
    .dbg_state(dbg_state)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks.
  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [1:0] lv, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input logic [4:0] w0, input logic [4:0] w1, input logic [1:0] rw);
    in_valid      = 1'b1;
    in_lane_valid = lv;
    in_pc         = {pc1, pc0};
    in_result     = {r1, r0};
    in_wreg       = {w1, w0};
    in_regwrite   = rw;
    in_hilo_we    = 1'b0;
    in_cp0_we     = 1'b0;
    in_hilo       = 64'd0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    idle();
    step(); step();
    check("rst_out_valid", out_valid, 0);
    reset = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid2", out_valid, 0);
    check("rst_out_pc", out_pc, {RPC, RPC});
    check("rst_regwrite", out_regwrite, 0);
    check("rst_state", dbg_state, 2'b00);

    // Streaming with out_ready high: one-cycle latency, in order.
    out_ready = 1'b1;
    drive(2'b01, 32'h100, 0, 32'h11, 0, 5'd1, 0, 2'b01); step();
    check("s1_valid", out_valid, 1);
    check("s1_result", out_result[31:0], 32'h11);
    check("s1_wreg", out_wreg[4:0], 1);
    check("s1_regwrite", out_regwrite, 2'b01);
    check("s1_ready", in_ready, 1);
    drive(2'b01, 32'h104, 0, 32'h22, 0, 5'd2, 0, 2'b01); step();
    check("s2_result", out_result[31:0], 32'h22);
    check("s2_pc", out_pc[31:0], 32'h104);
    check("s2_ready", in_ready, 1);
    drive(2'b01, 32'h108, 0, 32'h33, 0, 5'd3, 0, 2'b01); step();
    check("s3_result", out_result[31:0], 32'h33);
    check("s3_wreg", out_wreg[4:0], 3);
    check("s3_ready", in_ready, 1);
    idle(); step();
    check("s_drain_valid", out_valid, 0);
    check("s_drain_pc", out_pc, {RPC, RPC});

    // Backpressure: fill MAIN and SKID, then drain in order.
    out_ready = 1'b0;
    drive(2'b01, 32'h200, 0, 32'hA1, 0, 5'd7, 0, 2'b01); step();
    check("bp1_result", out_result[31:0], 32'hA1);
    check("bp1_ready", in_ready, 1);
    drive(2'b01, 32'h204, 0, 32'hB2, 0, 5'd8, 0, 2'b01); step();
    check("bp2_ready", in_ready, 0);
    check("bp2_state", dbg_state, 2'b11);
    check("bp2_hold", out_result[31:0], 32'hA1);
    drive(2'b01, 32'h208, 0, 32'hC3, 0, 5'd9, 0, 2'b01); step();
    check("bp3_hold", out_result[31:0], 32'hA1);
    check("bp3_wreg", out_wreg[4:0], 7);
    check("bp3_ready", in_ready, 0);
    idle(); out_ready = 1'b1; step();
    check("bp4_result", out_result[31:0], 32'hB2);
    check("bp4_wreg", out_wreg[4:0], 8);
    check("bp4_ready", in_ready, 1);
    check("bp4_state", dbg_state, 2'b01);
    step();
    check("bp5_valid", out_valid, 0);
    check("bp5_ready", in_ready, 1);

    // Same-register collision: younger lane wins.
    out_ready = 1'b0;
    drive(2'b11, 32'h300, 32'h304, 32'hAAAA, 32'hBBBB, 5'd5, 5'd5, 2'b11); step();
    check("col_regwrite", out_regwrite, 2'b10);
    check("col_result1", out_result[63:32], 32'hBBBB);
    out_ready = 1'b1;
    drive(2'b11, 32'h310, 32'h314, 32'hAAAA, 32'hBBBB, 5'd5, 5'd0, 2'b11); step();
    check("r0_regwrite", out_regwrite, 2'b01);
    drive(2'b01, 32'h320, 32'h324, 32'h1, 32'h2, 5'd6, 5'd6, 2'b11); step();
    check("col_lane1_invalid", out_regwrite, 2'b01);
    drive(2'b11, 32'h330, 32'h334, 32'h1, 32'h2, 5'd6, 5'd4, 2'b11); step();
    check("no_col_regwrite", out_regwrite, 2'b11);
    idle(); step();
    check("col_drain_regwrite", out_regwrite, 2'b00);

    // Flush in TWO together with an incoming bundle.
    out_ready = 1'b0;
    drive(2'b11, 32'h400, 32'h404, 32'h41, 32'h42, 5'd10, 5'd11, 2'b11); step();
    drive(2'b11, 32'h408, 32'h40c, 32'h43, 32'h44, 5'd12, 5'd13, 2'b11); step();
    check("fl_pre_state", dbg_state, 2'b11);
    drive(2'b11, 32'h410, 32'h414, 32'h45, 32'h46, 5'd14, 5'd15, 2'b11);
    in_hilo_we = 1'b1; in_cp0_we = 1'b1;
    flush = 1'b1; step();
    flush = 1'b0; idle();
    check("fl_valid", out_valid, 0);
    check("fl_pc", out_pc, {RPC, RPC});
    check("fl_result", out_result, 0);
    check("fl_wreg", out_wreg, 0);
    check("fl_enables", {out_regwrite, out_hilo_we, out_cp0_we}, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1; step();
    check("fl_discarded", out_valid, 0);

    // HI/LO and CP0 enables follow lane 0.
    out_ready = 1'b0;
    drive(2'b01, 32'h500, 0, 32'h51, 0, 5'd0, 0, 2'b00);
    in_hilo_we = 1'b1; in_hilo = 64'h1234_5678_9abc_def0; in_cp0_we = 1'b1; step();
    check("hl_we", out_hilo_we, 1);
    check("hl_cp0", out_cp0_we, 1);
    check("hl_data", out_hilo, 64'h1234_5678_9abc_def0);
    out_ready = 1'b1;
    drive(2'b10, 0, 32'h504, 0, 32'h52, 0, 5'd0, 2'b00);
    in_hilo_we = 1'b1; in_hilo = 64'h1234_5678_9abc_def0; in_cp0_we = 1'b1; step();
    check("hl_lane1_we", {out_hilo_we, out_cp0_we}, 2'b00);
    check("hl_lane1_valid", out_valid, 1);
    idle(); step();
    check("hl_drain_we", {out_hilo_we, out_cp0_we}, 2'b00);

    // Reset while in TWO discards both entries.
    out_ready = 1'b0;
    drive(2'b01, 32'h600, 0, 32'h61, 0, 5'd1, 0, 2'b01); step();
    drive(2'b01, 32'h604, 0, 32'h62, 0, 5'd2, 0, 2'b01); step();
    idle(); reset = 1'b1; flush = 1'b1; step();
    reset = 1'b0; flush = 1'b0;
    check("rt_valid", out_valid, 0);
    check("rt_ready", in_ready, 1);
    out_ready = 1'b1; step();
    check("rt_empty", out_valid, 0);

`ifdef WB_RETIRE_CNT_EN
    reset = 1'b1; step(); reset = 1'b0;
    check("rc_reset", retire_cnt, 0);
    out_ready = 1'b1;
    drive(2'b11, 32'h700, 32'h704, 1, 2, 0, 0, 2'b00); step();
    drive(2'b01, 32'h708, 32'h70c, 3, 4, 0, 0, 2'b00); step();
    drive(2'b11, 32'h710, 32'h714, 5, 6, 0, 0, 2'b00); step();
    idle(); step();
    check("rc_count", retire_cnt, 5);
    flush = 1'b1; step(); flush = 1'b0;
    check("rc_flush_keeps", retire_cnt, 5);
    force dut.retire_cnt_q = 32'hffff_ffff;
    #1;
    release dut.retire_cnt_q;
    drive(2'b11, 32'h720, 32'h724, 7, 8, 0, 0, 2'b00); step();
    idle(); step();
    check("rc_wrap", retire_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
